// File: rtl/alu_pkg.sv
// Shared ToyALU definitions: divider FSM states, default width and
// two's-complement helpers shared by the datapath blocks.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;
  // Helpers operate at this width; callers zero-extend and truncate back.
  localparam int DIV_MAX_WIDTH = 64;

  function automatic logic [DIV_MAX_WIDTH-1:0] twos_neg(input logic [DIV_MAX_WIDTH-1:0] x);
    return ~x + DIV_MAX_WIDTH'(1);
  endfunction

  // Conditional negate: yields |x| when neg flags a negative operand,
  // and applies the final sign fix to a magnitude result.
  function automatic logic [DIV_MAX_WIDTH-1:0] cond_neg(input logic [DIV_MAX_WIDTH-1:0] x,
                                                        input logic neg);
    return neg ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider. Both channels are
// valid/ready: a transfer happens on a rising edge where valid and ready are high.
interface seq_divider_if #(parameter int WIDTH = alu_pkg::DIV_WIDTH_DEFAULT);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtraction of the zero-extended divisor
// from the partial remainder, done as a + ~b + 1 like the adder datapath.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] trial,
  output logic             borrow
);

  logic [WIDTH+1:0] sum;

  assign sum   = {1'b0, partial} + {1'b0, ~{1'b0, divisor}} + (WIDTH+2)'(1);
  assign trial = sum[WIDTH-1:0];
  // The divisor's top bit is zero, so a negative difference always sets
  // sum[WIDTH]; the AND form is therefore identical to ~carry.
  assign borrow = sum[WIDTH] & ~sum[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on magnitudes,
// sign fixed on the way out, results held until the consumer takes them.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_divider_if.slave bus,
  output div_state_t dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic             q_neg;
  logic             r_neg;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
  // The most-negative value maps onto its own bit pattern, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  assign dvd_mag = WIDTH'(cond_neg(DIV_MAX_WIDTH'(bus.dividend), a_neg));
  assign dvs_mag = WIDTH'(cond_neg(DIV_MAX_WIDTH'(bus.divisor), b_neg));
  assign q_fix   = WIDTH'(cond_neg(DIV_MAX_WIDTH'(quot), q_neg));
  assign r_fix   = WIDTH'(cond_neg(DIV_MAX_WIDTH'(rem), r_neg));
  assign partial = {rem, dvd[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .partial (partial),
    .divisor (dvsr),
    .trial   (trial),
    .borrow  (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            dbz_r      <= 1'b0;
            cnt        <= '0;
            quot       <= '0;
            q_neg      <= a_neg ^ b_neg;
            r_neg      <= a_neg;
            dvd        <= dvd_mag;
            dvsr       <= dvs_mag;
            if (bus.divisor == '0) begin
              // Keep the raw dividend: it is the divide-by-zero remainder.
              rem   <= bus.dividend;
              state <= DONE;
            end else begin
              rem   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            quotient_r  <= q_fix;
            remainder_r <= r_fix;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            rem  <= borrow ? partial[WIDTH-1:0] : trial;
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
            quot <= {quot[WIDTH-2:0], ~borrow};
            cnt  <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!out_valid_r) begin
            // Only reached straight from IDLE on a zero divisor.
            quotient_r  <= '1;
            remainder_r <= rem;
            dbz_r       <= 1'b1;
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider: a driver pushes expected
// results from an arithmetic reference model, a monitor pops and compares.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  div_state_t dbg_state;
  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [2*W:0] exp_q[$];   // {div_by_zero, quotient, remainder}
  int           lat_q[$];   // cycle at which out_valid must first be seen

  task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint sa;
    longint sb;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
    return {1'b0, q, r};
  endfunction

  // ---------------- monitor ----------------
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [2*W:0] held = '0;
  logic [2*W:0] cur;
  logic [2*W:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      cur = {bus.div_by_zero, bus.quotient, bus.remainder};
      if (bus.out_valid && !pv) begin
        if (lat_q.size() == 0) chk("unexpected_valid", bus.out_valid, 0);
        else chk("latency_cycle", cyc, lat_q.pop_front());
      end
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", cur, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", bus.out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("quotient", bus.quotient, e[2*W-1:W]);
          chk("remainder", bus.remainder, e[W-1:0]);
          chk("div_by_zero", bus.div_by_zero, e[2*W]);
        end
      end
      pv   = bus.out_valid;
      pr   = bus.out_ready;
      held = cur;
    end
  end

  // ---------------- driver tasks ----------------
  bit rnd_mode = 0;
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    @(negedge clk);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(model(a, b, s));
    lat_q.push_back(cyc + ((b == 0) ? 1 : W + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] da[10] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'd5,
                           32'h80000000, 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFF};
  logic [W-1:0] db[10] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h7FFFFFFF, 32'h80000000};
  logic         ds[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // Directed corner cases, one at a time.
    for (int i = 0; i < 10; i++) begin
      issue(da[i], db[i], ds[i]);
      drain();
    end

    // Consumer stall: outputs hold, new operands ignored.
    bus.out_ready = 1'b0;
    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_out_valid", bus.out_valid, 1);
    hq = bus.quotient;
    hr = bus.remainder;
    bus.dividend = 32'd123;
    bus.divisor  = 32'd4;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_quotient", bus.quotient, hq);
      chk("stall_remainder", bus.remainder, hr);
      chk("stall_state", dbg_state, DONE);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    issue(32'd1, 32'hFFFFFFFF, 1'b0);
    drain();

    // Asynchronous reset in the middle of a calculation.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    chk("abort_state", dbg_state, CALC);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd9, 32'd3, 1'b0);
    drain();

    // Random operations with a randomly stalling consumer.
    rnd_mode = 1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        4:       rb = 32'hFFFFFFFF;
        default: rb = $urandom();
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_mode = 0;
    #1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_latency_queue", lat_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
